// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits a W-bit pattern MSB first, repeated reps times
// with optional idle-low gaps, as a stimulus source for serial sequence detectors.
module seq_pattern_gen #(
  parameter int              W       = 5,
  parameter logic [W-1:0]    PATTERN = 5'b10010,
  parameter int              CNT_W   = 4,
  parameter int              GAP_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [W-1:0]     pat_in,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             j,
  output logic             j_valid,
  output logic             busy,
  output logic             done,
  output logic             last_bit
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [W-1:0]     r_pat;
  logic [CNT_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap_ld;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_j, r_valid, r_busy, r_done, r_last;

  logic [1:0]       w_state_nx;
  logic [W-1:0]     w_pat_nx;
  logic [CNT_W-1:0] w_rep_nx;
  logic [GAP_W-1:0] w_gap_ld_nx;
  logic [GAP_W-1:0] w_gap_cnt_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_load;
  logic             w_j_nx, w_valid_nx, w_busy_nx, w_done_nx, w_last_nx;

  always_comb begin
    w_state_nx   = r_state;
    w_pat_nx     = r_pat;
    w_rep_nx     = r_rep;
    w_gap_ld_nx  = r_gap_ld;
    w_gap_cnt_nx = r_gap_cnt;
    w_idx_nx     = r_idx;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_nx    = use_def ? PATTERN : pat_in;
          w_rep_nx    = reps;
          w_gap_ld_nx = gap;
          if (reps != '0) w_load = 1'b1;
          else            w_state_nx = S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_idx != '0) begin
          w_idx_nx = r_idx - IDX_W'(1);
        end else begin
          // Final bit of a repetition is on the line now; decide what follows it.
          w_rep_nx = r_rep - CNT_W'(1);
          if (w_rep_nx == '0) begin
            w_state_nx = S_DONE;
          end else if (r_gap_ld != '0) begin
            w_state_nx   = S_GAP;
            w_gap_cnt_nx = r_gap_ld;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) w_load = 1'b1;
        else                        w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_state_nx = S_SHIFT;
      w_idx_nx   = IDX_TOP;
    end

    // Outputs are registered from the next state so they line up with it cycle-for-cycle.
    w_valid_nx = (w_state_nx == S_SHIFT);
    w_busy_nx  = (w_state_nx == S_SHIFT) || (w_state_nx == S_GAP);
    w_done_nx  = (w_state_nx == S_DONE);
    w_j_nx     = w_valid_nx & w_pat_nx[w_idx_nx];
    w_last_nx  = w_valid_nx && (w_idx_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_rep     <= '0;
      r_gap_ld  <= '0;
      r_gap_cnt <= '0;
      r_idx     <= '0;
      r_j       <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pat     <= w_pat_nx;
      r_rep     <= w_rep_nx;
      r_gap_ld  <= w_gap_ld_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_idx     <= w_idx_nx;
      r_j       <= w_j_nx;
      r_valid   <= w_valid_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_last    <= w_last_nx;
    end
  end

  assign j        = r_j;
  assign j_valid  = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign last_bit = r_last;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: a per-cycle expected-output scoreboard
// built from an independent model of the transmit sequence.
module tb_seq_pattern_gen;
  localparam int W     = 5;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             use_def;
  logic [W-1:0]     pat_in;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             j, j_valid, busy, done, last_bit;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected vector per cycle: {j, j_valid, busy, done, last_bit}
  logic [4:0] exp_q[$];

  seq_pattern_gen #(.W(W), .PATTERN(5'b10010), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .use_def(use_def), .pat_in(pat_in),
    .reps(reps), .gap(gap), .j(j), .j_valid(j_valid), .busy(busy), .done(done),
    .last_bit(last_bit)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {j, j_valid, busy, done, last_bit};
  endfunction

  // Independent model: bits MSB first, gap idle cycles between reps, one done cycle, then idle.
  task automatic build_expect(input logic [W-1:0] pat, input int nreps, input int ngap);
    exp_q.delete();
    for (int r = 0; r < nreps; r++) begin
      for (int b = W - 1; b >= 0; b--)
        exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0, (b == 0)});
      if (r < nreps - 1)
        for (int g = 0; g < ngap; g++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
  endtask

  // Starts a transmission and checks every following cycle against the scoreboard.
  // poke: hold start / scramble inputs while busy or done. abort_at: assert rst during that cycle.
  task automatic run_tx(input string name, input logic ud, input logic [W-1:0] pat,
                        input int nreps, input int ngap, input bit poke, input int abort_at);
    logic [W-1:0] eff_pat;
    logic [4:0]   e;
    int           cyc;
    eff_pat = ud ? 5'b10010 : pat;
    build_expect(eff_pat, nreps, ngap);
    @(negedge clk);
    use_def = ud; pat_in = pat; reps = CNT_W'(nreps); gap = GAP_W'(ngap); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got {j,v,busy,done,last}=%b expected %b", name, cyc, obs(), e);
      end else begin
        $display("ok   %s cycle %0d: {j,v,busy,done,last}=%b", name, cyc, obs());
      end
      if (poke) begin
        start   = (e[2] | e[1]);
        use_def = 1'($urandom_range(0, 1));
        pat_in  = W'($urandom);
        reps    = CNT_W'($urandom);
        gap     = GAP_W'($urandom);
      end
      if (abort_at != 0 && cyc == abort_at) begin
        rst = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(5'b00000);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; use_def = 1'b1; reps = 4'd3; gap = 3'd0; pat_in = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b expected 00000", c, obs());
      end else begin
        $display("ok   reset cycle %0d: outputs %b", c, obs());
      end
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 00000", obs());
    end else begin
      $display("ok   reset_release: outputs %b", obs());
    end
  endtask

  task automatic test_default_single();
    run_tx("default_single", 1'b1, 5'b00000, 1, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_tx("back_to_back", 1'b1, 5'b00000, 2, 0, 1'b0, 0);
  endtask

  task automatic test_gap();
    run_tx("gap", 1'b0, 5'b11001, 3, 2, 1'b1, 0);
  endtask

  task automatic test_reps_zero();
    run_tx("reps_zero", 1'b0, 5'b10101, 0, 3, 1'b1, 0);
  endtask

  task automatic test_ignore_start();
    run_tx("ignore_start", 1'b0, 5'b01101, 2, 1, 1'b1, 0);
  endtask

  task automatic test_abort();
    run_tx("abort", 1'b1, 5'b00000, 4, 0, 1'b0, 8);
    run_tx("after_abort", 1'b0, 5'b10111, 1, 0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; use_def = 1'b0; pat_in = '0; reps = '0; gap = '0;
    test_reset();
    test_default_single();
    test_back_to_back();
    test_gap();
    test_reps_zero();
    test_ignore_start();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
